dmt_bin_buffer: RTL and testbench

Ping-pong frequency-domain frame buffer directly downstream of `const_encoder`. Captures per-bin constellation points (`x`/`y` with bin number) as the encoder produces them, in any bin order, into the write bank. It then streams one complete DMT symbol in ascending bin order to the IFFT stage over a valid/ready handshake. Bins not loaded during a frame are emitted as zero.

---
 rtl/dmt_pkg.sv | 19 +
 rtl/dmt_bin_bank.sv | 41 ++++
 rtl/dmt_bin_buffer.sv | 132 +++++++++++++
 tb/tb_dmt_bin_buffer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmt_pkg.sv
// Shared widths, point layout and read-FSM encoding for the DMT frequency-domain path.
package dmt_pkg;

    localparam int unsigned DMT_ADDR_W   = 8;
    localparam int unsigned DMT_DATA_W   = 15;
    localparam int unsigned DMT_NUM_BINS = 2 ** DMT_ADDR_W;
    localparam int unsigned DMT_PT_W     = 2 * DMT_DATA_W;

    typedef struct packed {
        logic [DMT_DATA_W-1:0] x;
        logic [DMT_DATA_W-1:0] y;
    } point_t;

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_t;

endpackage

// File: rtl/dmt_bin_bank.sv
// One frame bank: {x,y} storage per bin plus a loaded bitmap with synchronous clear.
module dmt_bin_bank
    import dmt_pkg::*;
#(
    parameter int unsigned ADDR_W = DMT_ADDR_W,
    parameter int unsigned DATA_W = DMT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_x,
    input  logic [DATA_W-1:0] wr_y,
    input  logic              clr,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_x,
    output logic [DATA_W-1:0] rd_y,
    output logic              rd_loaded
);

    localparam int unsigned NUM_BINS = 2 ** ADDR_W;

    logic [2*DATA_W-1:0] mem [NUM_BINS];
    logic [NUM_BINS-1:0] loaded;

    // Storage needs no reset: the bitmap masks stale entries.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= {wr_x, wr_y};
    end

    // Clear beats a same-cycle write so a discarded frame leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     loaded <= '0;
        else if (clr)   loaded <= '0;
        else if (wr_en) loaded[wr_addr] <= 1'b1;
    end

    assign {rd_x, rd_y} = mem[rd_addr];
    assign rd_loaded    = loaded[rd_addr];

endmodule

// File: rtl/dmt_bin_buffer.sv
// Ping-pong bin buffer: captures encoder points in any order, streams a full symbol in bin order.
module dmt_bin_buffer
    import dmt_pkg::*;
#(
    parameter int unsigned ADDR_W = DMT_ADDR_W,
    parameter int unsigned DATA_W = DMT_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              xy_ready_i,
    input  logic [ADDR_W-1:0] bin_num_i,
    input  logic [DATA_W-1:0] x_i,
    input  logic [DATA_W-1:0] y_i,
    input  logic              frame_end_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ADDR_W-1:0] out_bin_o,
    output logic [DATA_W-1:0] out_re_o,
    output logic [DATA_W-1:0] out_im_o,
    output logic              out_last_o,
    output logic              busy_o,
    output logic              drop_o
);

    logic [1:0]        rst_sync;
    logic              rst_n;
    rd_state_t         state, state_nxt;
    logic              wr_bank, wr_bank_nxt;
    logic              valid_nxt, last_nxt, drop_nxt;
    logic [ADDR_W-1:0] bin_nxt, rd_addr;
    logic [DATA_W-1:0] re_nxt, im_nxt;
    logic              accept, can_swap, swap;
    logic [DATA_W-1:0] b0_x, b0_y, b1_x, b1_y, rd_x, rd_y;
    logic              b0_ld, b1_ld, rd_ld;

    // Asynchronous assert, clock-synchronous release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign accept   = out_valid_o && out_ready_i;
    assign can_swap = (state == RD_IDLE) || (accept && out_last_o);
    assign swap     = frame_end_i && can_swap;
    assign rd_addr  = out_bin_o + ADDR_W'(1);

    dmt_bin_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank0 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(xy_ready_i && !wr_bank), .wr_addr(bin_num_i), .wr_x(x_i), .wr_y(y_i),
        .clr(frame_end_i && (can_swap ? wr_bank : !wr_bank)),
        .rd_addr(rd_addr), .rd_x(b0_x), .rd_y(b0_y), .rd_loaded(b0_ld)
    );

    dmt_bin_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank1 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(xy_ready_i && wr_bank), .wr_addr(bin_num_i), .wr_x(x_i), .wr_y(y_i),
        .clr(frame_end_i && (can_swap ? !wr_bank : wr_bank)),
        .rd_addr(rd_addr), .rd_x(b1_x), .rd_y(b1_y), .rd_loaded(b1_ld)
    );

    // The read bank is always the one not being filled.
    assign rd_x  = wr_bank ? b0_x  : b1_x;
    assign rd_y  = wr_bank ? b0_y  : b1_y;
    assign rd_ld = wr_bank ? b0_ld : b1_ld;

    // Next beat; bin 0 is DC and always zero, so the first beat never reads a bank.
    always_comb begin
        state_nxt   = state;
        wr_bank_nxt = wr_bank;
        valid_nxt   = out_valid_o;
        bin_nxt     = out_bin_o;
        re_nxt      = out_re_o;
        im_nxt      = out_im_o;
        last_nxt    = out_last_o;
        drop_nxt    = frame_end_i && !can_swap;
        if (swap) wr_bank_nxt = !wr_bank;
        case (state)
            RD_IDLE: begin
                if (swap) begin
                    state_nxt = RD_STREAM;
                    valid_nxt = 1'b1;
                    bin_nxt   = '0;
                    re_nxt    = '0;
                    im_nxt    = '0;
                    last_nxt  = 1'b0;
                end
            end
            RD_STREAM: begin
                if (accept && out_last_o) begin
                    state_nxt = swap ? RD_STREAM : RD_IDLE;
                    valid_nxt = swap;
                    bin_nxt   = '0;
                    re_nxt    = '0;
                    im_nxt    = '0;
                    last_nxt  = 1'b0;
                end else if (accept) begin
                    bin_nxt  = rd_addr;
                    re_nxt   = rd_ld ? rd_x : '0;
                    im_nxt   = rd_ld ? rd_y : '0;
                    last_nxt = (rd_addr == {ADDR_W{1'b1}});
                end
            end
            default: state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RD_IDLE;
            wr_bank     <= 1'b0;
            out_valid_o <= 1'b0;
            out_bin_o   <= '0;
            out_re_o    <= '0;
            out_im_o    <= '0;
            out_last_o  <= 1'b0;
            drop_o      <= 1'b0;
        end else begin
            state       <= state_nxt;
            wr_bank     <= wr_bank_nxt;
            out_valid_o <= valid_nxt;
            out_bin_o   <= bin_nxt;
            out_re_o    <= re_nxt;
            out_im_o    <= im_nxt;
            out_last_o  <= last_nxt;
            drop_o      <= drop_nxt;
        end
    end

    assign busy_o = (state == RD_STREAM);

endmodule

// File: tb/tb_dmt_bin_buffer.sv
// Bench for dmt_bin_buffer: directed frames plus random data/backpressure against a symbol-queue model.
module tb_dmt_bin_buffer;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 15;
    localparam int unsigned NB = 256;

    typedef struct {
        int          bin;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          xy_ready_i = 1'b0;
    logic [AW-1:0] bin_num_i = '0;
    logic [DW-1:0] x_i = '0;
    logic [DW-1:0] y_i = '0;
    logic          frame_end_i = 1'b0;
    logic          out_ready_i = 1'b0;
    logic          out_valid_o, out_last_o, busy_o, drop_o;
    logic [AW-1:0] out_bin_o;
    logic [DW-1:0] out_re_o, out_im_o;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: the frame being filled, and the beats still owed to the IFFT.
    logic [DW-1:0] fx [NB];
    logic [DW-1:0] fy [NB];
    bit            fld [NB];
    beat_t         q [$];
    bit            exp_drop = 1'b0;

    dmt_bin_buffer dut (
        .clk(clk), .reset(reset), .xy_ready_i(xy_ready_i), .bin_num_i(bin_num_i),
        .x_i(x_i), .y_i(y_i), .frame_end_i(frame_end_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .out_bin_o(out_bin_o), .out_re_o(out_re_o),
        .out_im_o(out_im_o), .out_last_o(out_last_o), .busy_o(busy_o), .drop_o(drop_o)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic clear_frame();
        for (int b = 0; b < NB; b++) fld[b] = 1'b0;
    endtask

    task automatic push_frame();
        beat_t bt;
        for (int b = 0; b < NB; b++) begin
            bt.bin = b;
            bt.re  = (b != 0 && fld[b]) ? fx[b] : '0;
            bt.im  = (b != 0 && fld[b]) ? fy[b] : '0;
            q.push_back(bt);
        end
    endtask

    task automatic check_outputs();
        chk("valid", 32'(out_valid_o), 32'(q.size() > 0));
        chk("busy", 32'(busy_o), 32'(q.size() > 0));
        chk("drop", 32'(drop_o), 32'(exp_drop));
        if (q.size() > 0) begin
            chk("bin", 32'(out_bin_o), 32'(q[0].bin));
            chk("re", 32'(out_re_o), 32'(q[0].re));
            chk("im", 32'(out_im_o), 32'(q[0].im));
            chk("last", 32'(out_last_o), 32'(q[0].bin == NB - 1));
        end
    endtask

    // One clock: drive inputs, advance the model by the same edge, then compare.
    task automatic cyc(input bit xy, input int bin, input logic [DW-1:0] x, input logic [DW-1:0] y,
                       input bit fe, input bit rdy);
        bit acc, can_swap;
        xy_ready_i  = xy;
        bin_num_i   = AW'(bin);
        x_i         = x;
        y_i         = y;
        frame_end_i = fe;
        out_ready_i = rdy;
        acc      = (q.size() > 0) && rdy;
        can_swap = (q.size() == 0) || (acc && q.size() == 1);
        @(posedge clk);
        #1;
        if (acc) void'(q.pop_front());
        if (xy) begin
            fx[bin]  = x;
            fy[bin]  = y;
            fld[bin] = 1'b1;
        end
        exp_drop = 1'b0;
        if (fe) begin
            if (can_swap) push_frame();
            else exp_drop = 1'b1;
            clear_frame();
        end
        xy_ready_i  = 1'b0;
        frame_end_i = 1'b0;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, '0, '0, 0, 1);
    endtask

    task automatic drain(input bit rnd);
        int n = 0;
        while (q.size() > 0 && n < 3000) begin
            cyc(0, 0, '0, '0, 0, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            n++;
        end
        chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    task automatic wr_rand(input int n, input bit rdy_rnd);
        for (int i = 0; i < n; i++)
            cyc(1, int'($urandom_range(0, NB - 1)), DW'($urandom), DW'($urandom), 0,
                rdy_rnd ? 1'($urandom_range(0, 1)) : 1'b1);
    endtask

    // Stream with ready high until the model's next beat is the given bin.
    task automatic run_to_bin(input int target, input bit write_b);
        int n = 0;
        while (q.size() > 0 && q[0].bin != target && n < 600) begin
            if (write_b) cyc(1, int'($urandom_range(1, NB - 1)), DW'($urandom), DW'($urandom), 0, 1);
            else         cyc(0, 0, '0, '0, 0, 1);
            n++;
        end
        chk("reach_bin", 32'(q.size() > 0 && q[0].bin == target), 32'd1);
    endtask

    initial begin
        clear_frame();
        #2 reset = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid_o), 32'd0);
        chk("rst_bin", 32'(out_bin_o), 32'd0);
        chk("rst_re", 32'(out_re_o), 32'd0);
        chk("rst_im", 32'(out_im_o), 32'd0);
        chk("rst_last", 32'(out_last_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_drop", 32'(drop_o), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        idle(4);

        // Sparse out-of-order frame
        cyc(1, 5, DW'(100), DW'(-100), 0, 1);
        cyc(1, 1, DW'(7), DW'(8), 0, 1);
        cyc(1, 3, DW'(-1), DW'(1), 0, 1);
        cyc(0, 0, '0, '0, 1, 1);
        drain(0);
        idle(2);

        // DC forced to zero, last write wins
        cyc(1, 0, DW'(50), DW'(50), 0, 1);
        cyc(1, 9, DW'(1), DW'(1), 0, 1);
        cyc(1, 9, DW'(2), DW'(2), 1, 1);
        drain(0);
        idle(2);

        // Random contents under random backpressure
        wr_rand(40, 0);
        cyc(0, 0, '0, '0, 1, 1);
        drain(1);
        idle(2);

        // Frame B closed mid-stream is dropped; frame C follows cleanly
        wr_rand(20, 0);
        cyc(0, 0, '0, '0, 1, 1);
        run_to_bin(100, 1);
        cyc(1, 77, DW'(1234), DW'(4321), 1, 1);
        drain(0);
        wr_rand(20, 0);
        cyc(0, 0, '0, '0, 1, 1);
        drain(1);
        idle(2);

        // Frame B closed exactly on A's final accepted beat: no gap, no drop
        wr_rand(15, 0);
        cyc(0, 0, '0, '0, 1, 1);
        run_to_bin(NB - 1, 1);
        cyc(1, 200, DW'($urandom), DW'($urandom), 1, 1);
        drain(0);
        idle(2);

        // Reset mid-stream aborts the symbol
        wr_rand(25, 0);
        cyc(0, 0, '0, '0, 1, 1);
        run_to_bin(40, 0);
        reset = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid_o), 32'd0);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_bin", 32'(out_bin_o), 32'd0);
        q.delete();
        clear_frame();
        exp_drop = 1'b0;
        idle(2);
        reset = 1'b1;
        idle(4);
        cyc(0, 0, '0, '0, 1, 1);
        drain(1);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
